// File: rtl/alu_pkg.sv
// alu_pkg: shared width constant and operation encoding for the execute-stage ALU
package alu_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SLTU  = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode inputs and combinational/registered results of the ALU
interface alu_if import alu_pkg::*; ();
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] rd;
    logic            z;
    logic [XLEN-1:0] rd_q;
    logic            z_q;
    modport master (output rs1, rs2, ctrl, input rd, z, rd_q, z_q);
    modport slave  (input rs1, rs2, ctrl, output rd, z, rd_q, z_q);
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: one XLEN+1 adder doing add or subtract; subtract also yields signed/unsigned less-than
module alu_addsub import alu_pkg::*; (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            lt,
    output logic            ltu
);
    logic [XLEN:0] full;
    logic          ovf;
    assign full = {1'b0, a} + {1'b0, b ^ {XLEN{sub}}} + {{XLEN{1'b0}}, sub};
    assign sum  = full[XLEN-1:0];
    assign ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (sum[XLEN-1] ^ a[XLEN-1]);
    assign ltu  = ~full[XLEN];
    assign lt   = sum[XLEN-1] ^ ovf;
endmodule

// File: rtl/alu_unit.sv
// alu_unit: op mux, zero detect and pipeline registers around the shared adder
module alu_unit import alu_pkg::*; (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] rd;
    logic            lt;
    logic            ltu;
    logic            sub;
    assign sub = bus.ctrl != ALU_ADD;
    alu_addsub u_addsub (
        .a   (bus.rs1),
        .b   (bus.rs2),
        .sub (sub),
        .sum (sum),
        .lt  (lt),
        .ltu (ltu)
    );
    // select the result for the current opcode
    always_comb begin
        case (alu_op_e'(bus.ctrl))
            ALU_ADD, ALU_SUB: rd = sum;
            ALU_AND:          rd = bus.rs1 & bus.rs2;
            ALU_OR:           rd = bus.rs1 | bus.rs2;
            ALU_XOR:          rd = bus.rs1 ^ bus.rs2;
            ALU_SLT:          rd = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU:         rd = {{(XLEN-1){1'b0}}, ltu};
            ALU_PASSB:        rd = bus.rs2;
            default:          rd = '0;
        endcase
    end
    assign bus.rd = rd;
    assign bus.z  = rd == '0;
    // capture result and flag for the next stage every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_q <= '0;
            bus.z_q  <= 1'b0;
        end else begin
            bus.rd_q <= rd;
            bus.z_q  <= rd == '0;
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results for alu_unit
module tb_alu_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    alu_if bus ();
    alu_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl = op;
        bus.rs1  = a;
        bus.rs2  = b;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        apply(3'b000, 32'd0, 32'd0);
        check("reset rd_q", bus.rd_q, 32'd0);
        check("reset z_q", {31'b0, bus.z_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'b000, 32'd20, 32'd30);
        check("add rd", bus.rd, 32'd50);
        check("add z", {31'b0, bus.z}, 32'd0);
        tick();
        check("add rd_q", bus.rd_q, 32'd50);
        check("add z_q", {31'b0, bus.z_q}, 32'd0);
        apply(3'b001, 32'd8, 32'd3);
        check("sub 8-3 rd", bus.rd, 32'd5);
        check("sub 8-3 z", {31'b0, bus.z}, 32'd0);
        apply(3'b001, 32'd20, 32'd20);
        check("sub eq rd", bus.rd, 32'd0);
        check("sub eq z", {31'b0, bus.z}, 32'd1);
        apply(3'b001, 32'd0, 32'd1);
        check("sub wrap rd", bus.rd, 32'hFFFF_FFFF);
        apply(3'b010, 32'd20, 32'd30);
        check("and rd", bus.rd, 32'd20);
        apply(3'b011, 32'd20, 32'd30);
        check("or rd", bus.rd, 32'd30);
        apply(3'b100, 32'd20, 32'd30);
        check("xor rd", bus.rd, 32'd10);
        apply(3'b111, 32'd20, 32'd30);
        check("passb rd", bus.rd, 32'd30);
        apply(3'b101, 32'd20, 32'd30);
        check("slt lt rd", bus.rd, 32'd1);
        apply(3'b101, 32'd30, 32'd20);
        check("slt ge rd", bus.rd, 32'd0);
        check("slt ge z", {31'b0, bus.z}, 32'd1);
        apply(3'b101, 32'hFFFF_FFFF, 32'd1);
        check("slt neg rd", bus.rd, 32'd1);
        apply(3'b110, 32'hFFFF_FFFF, 32'd1);
        check("sltu big rd", bus.rd, 32'd0);
        apply(3'b110, 32'd1, 32'hFFFF_FFFF);
        check("sltu small rd", bus.rd, 32'd1);
        apply(3'b101, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt ovf rd", bus.rd, 32'd1);
        apply(3'b000, 32'd20, 32'd30);
        tick();
        check("pre-reset rd_q", bus.rd_q, 32'd50);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rd_q", bus.rd_q, 32'd0);
        check("async reset z_q", {31'b0, bus.z_q}, 32'd0);
        check("reset rd held", bus.rd, 32'd50);
        tick();
        check("reset hold rd_q", bus.rd_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset rd_q", bus.rd_q, 32'd50);
        apply(3'b000, 32'hFFFF_FFFF, 32'd1);
        check("add wrap rd", bus.rd, 32'd0);
        check("add wrap z", {31'b0, bus.z}, 32'd1);
        tick();
        check("add wrap z_q", {31'b0, bus.z_q}, 32'd1);
        check("add wrap rd_q", bus.rd_q, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
